// File: rtl/cache_pkg.sv
// Shared types and width helpers for the write-back set-associative cache.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_REFILL    = 3'd3,
        ST_RESPOND   = 3'd4
    } state_e;

    // Set-index width: the low address bits select the set.
    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    // Tag width: whatever address bits remain above the index.
    function automatic int tag_width(input int addr_w, input int sets);
        return addr_w - $clog2(sets);
    endfunction

    // Age / way-number width; ages are a permutation of 0..WAYS-1.
    function automatic int age_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// LRU bookkeeping for one set: victim choice and age update after an access.
module cache_lru
    import cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int AGE_W = age_width(WAYS)
) (
    input  logic [WAYS-1:0]       valid_i,
    input  logic [WAYS*AGE_W-1:0] ages_i,
    input  logic [AGE_W-1:0]      used_way_i,
    output logic [AGE_W-1:0]      victim_o,
    output logic [WAYS*AGE_W-1:0] ages_o
);

    logic [AGE_W-1:0] used_age;

    // Victim: lowest-index invalid way wins, otherwise the oldest way.
    always_comb begin
        victim_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (ages_i[w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) begin
                victim_o = AGE_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                victim_o = AGE_W'(w);
            end
        end
    end

    // Used way becomes youngest; every younger way ages by one.
    always_comb begin
        used_age = '0;
        ages_o   = ages_i;
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == used_way_i) begin
                used_age = ages_i[w*AGE_W +: AGE_W];
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == used_way_i) begin
                ages_o[w*AGE_W +: AGE_W] = '0;
            end else if (ages_i[w*AGE_W +: AGE_W] < used_age) begin
                ages_o[w*AGE_W +: AGE_W] = ages_i[w*AGE_W +: AGE_W] + AGE_W'(1);
            end
        end
    end

endmodule

// File: rtl/assoc_cache_wb.sv
// Write-back, write-allocate set-associative cache with one-word lines.
//
//   state     | meaning
//   IDLE      | ready for a request
//   LOOKUP    | tag compare; hit completes, miss picks a victim
//   WRITEBACK | flushing dirty victim to backing memory
//   REFILL    | fetching requested word; victim replaced on ack
//   RESPOND   | one-cycle completion pulse
module assoc_cache_wb
    import cache_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3,
    parameter int SETS   = 4,
    parameter int WAYS   = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wren,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int IDX_W = idx_width(SETS);
    localparam int TAG_W = tag_width(ADDR_W, SETS);
    localparam int AGE_W = age_width(WAYS);

    state_e state_q, state_d;

    logic              wren_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [AGE_W-1:0]  victim_q, victim_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              valid_q [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic [AGE_W-1:0]  age_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [WAYS-1:0]       set_valid;
    logic [WAYS*AGE_W-1:0] set_ages;
    logic [WAYS*AGE_W-1:0] new_ages;
    logic                  hit_any;
    logic [AGE_W-1:0]      hit_way;
    logic [DATA_W-1:0]     hit_data;
    logic [AGE_W-1:0]      victim;

    logic              line_we;
    logic [AGE_W-1:0]  line_way;
    logic [DATA_W-1:0] line_data;
    logic              line_dirty;
    logic              lru_we;
    logic [AGE_W-1:0]  used_way;

    assign idx = addr_q[IDX_W-1:0];
    assign tag = addr_q[ADDR_W-1:IDX_W];

    // Gather the addressed set and compare tags.
    always_comb begin
        set_valid = '0;
        set_ages  = '0;
        hit_any   = 1'b0;
        hit_way   = '0;
        hit_data  = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w]                = valid_q[idx][w];
            set_ages[w*AGE_W +: AGE_W]  = age_q[idx][w];
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit_any  = 1'b1;
                hit_way  = AGE_W'(w);
                hit_data = data_q[idx][w];
            end
        end
    end

    cache_lru #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_lru (
        .valid_i    (set_valid),
        .ages_i     (set_ages),
        .used_way_i (used_way),
        .victim_o   (victim),
        .ages_o     (new_ages)
    );

    // State register; reset abandons any memory transaction immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, outputs and line/LRU write strobes.
    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        hit_d      = hit_q;
        rdata_d    = rdata_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        resp_data  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        line_we    = 1'b0;
        line_way   = victim_q;
        line_data  = '0;
        line_dirty = 1'b0;
        lru_we     = 1'b0;
        used_way   = victim_q;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit_any) begin
                    used_way = hit_way;
                    lru_we   = 1'b1;
                    hit_d    = 1'b1;
                    rdata_d  = hit_data;
                    if (wren_q) begin
                        line_we    = 1'b1;
                        line_way   = hit_way;
                        line_data  = wdata_q;
                        line_dirty = 1'b1;
                        rdata_d    = wdata_q;
                    end
                    state_d = ST_RESPOND;
                end else begin
                    victim_d = victim;
                    hit_d    = 1'b0;
                    if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_REFILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[idx][victim_q], idx};
                mem_wdata = data_q[idx][victim_q];
                if (mem_ack) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) begin
                    line_we    = 1'b1;
                    line_data  = wren_q ? wdata_q : mem_rdata;
                    line_dirty = wren_q;
                    lru_we     = 1'b1;
                    hit_d      = 1'b0;
                    rdata_d    = line_data;
                    state_d    = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                resp_valid = 1'b1;
                resp_hit   = hit_q;
                resp_data  = rdata_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture and per-access bookkeeping registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wren_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            victim_q <= '0;
            hit_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if ((state_q == ST_IDLE) && req_valid) begin
                wren_q  <= req_wren;
                addr_q  <= req_addr;
                wdata_q <= req_data;
            end
            victim_q <= victim_d;
            hit_q    <= hit_d;
            rdata_q  <= rdata_d;
        end
    end

    // Line storage and ages; reset invalidates everything and seeds age = way.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AGE_W'(w);
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                end
            end
        end else begin
            if (lru_we) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[idx][w] <= new_ages[w*AGE_W +: AGE_W];
                end
            end
            if (line_we) begin
                valid_q[idx][line_way] <= 1'b1;
                dirty_q[idx][line_way] <= line_dirty;
                tag_q[idx][line_way]   <= tag;
                data_q[idx][line_way]  <= line_data;
            end
        end
    end

endmodule

// File: tb/tb_assoc_cache_wb.sv
// Bench for assoc_cache_wb: a 2-way/4-set instance and a 4-way/8-set instance,
// each served by a bench memory and compared against a recency-list cache model.
module tb_assoc_cache_wb;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic       a_req_valid, a_req_ready, a_req_wren;
    logic [4:0] a_req_addr;
    logic [2:0] a_req_data;
    logic       a_resp_valid, a_resp_hit;
    logic [2:0] a_resp_data;
    logic       a_mem_req, a_mem_we, a_mem_ack;
    logic [4:0] a_mem_addr;
    logic [2:0] a_mem_wdata, a_mem_rdata;

    logic       b_req_valid, b_req_ready, b_req_wren;
    logic [6:0] b_req_addr;
    logic [7:0] b_req_data;
    logic       b_resp_valid, b_resp_hit;
    logic [7:0] b_resp_data;
    logic       b_mem_req, b_mem_we, b_mem_ack;
    logic [6:0] b_mem_addr;
    logic [7:0] b_mem_wdata, b_mem_rdata;

    assoc_cache_wb #(.ADDR_W(5), .DATA_W(3), .SETS(4), .WAYS(2)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wren(a_req_wren),
        .req_addr(a_req_addr), .req_data(a_req_data),
        .resp_valid(a_resp_valid), .resp_hit(a_resp_hit), .resp_data(a_resp_data),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_ack(a_mem_ack), .mem_rdata(a_mem_rdata)
    );

    assoc_cache_wb #(.ADDR_W(7), .DATA_W(8), .SETS(8), .WAYS(4)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wren(b_req_wren),
        .req_addr(b_req_addr), .req_data(b_req_data),
        .resp_valid(b_resp_valid), .resp_hit(b_resp_hit), .resp_data(b_resp_data),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int env_mem [2][128];
    int ref_mem [2][128];
    int wb_cnt [2], wb_addr [2], wb_data [2], rf_cnt [2], rf_addr [2];
    bit ack_en [2];
    int dly [2];

    // Reference model: per set, lines kept in recency order (slot 0 = most recent).
    int m_tag   [2][8][4];
    int m_data  [2][8][4];
    bit m_dirty [2][8][4];
    int m_cnt   [2][8];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < 8; s++) m_cnt[c][s] = 0;
    endfunction

    function automatic void init_mem();
        int v;
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 128; a++) begin
                v = int'($urandom_range(0, (c == 1) ? 255 : 7));
                env_mem[c][a] = v;
                ref_mem[c][a] = v;
            end
    endfunction

    function automatic void model_access(input int cfg, input bit wr, input int addr, input int data,
                                         output bit hit, output int d, output bit wb,
                                         output int wba, output int wbd);
        int sets, ways, s, t, k, cnt, nd;
        bit ndirty;
        sets = (cfg == 1) ? 8 : 4;
        ways = (cfg == 1) ? 4 : 2;
        s = addr % sets;
        t = addr / sets;
        cnt = m_cnt[cfg][s];
        k = -1; wb = 0; wba = 0; wbd = 0;
        for (int i = 0; i < cnt; i++) if (m_tag[cfg][s][i] == t) k = i;
        if (k >= 0) begin
            hit = 1;
            nd = m_data[cfg][s][k];
            ndirty = m_dirty[cfg][s][k];
            if (wr) begin nd = data; ndirty = 1; end
            for (int i = k; i > 0; i--) begin
                m_tag[cfg][s][i] = m_tag[cfg][s][i-1];
                m_data[cfg][s][i] = m_data[cfg][s][i-1];
                m_dirty[cfg][s][i] = m_dirty[cfg][s][i-1];
            end
        end else begin
            hit = 0;
            if (cnt == ways) begin
                if (m_dirty[cfg][s][ways-1]) begin
                    wb = 1;
                    wba = m_tag[cfg][s][ways-1] * sets + s;
                    wbd = m_data[cfg][s][ways-1];
                    ref_mem[cfg][wba] = wbd;
                end
                cnt--;
            end
            nd = wr ? data : ref_mem[cfg][addr];
            ndirty = wr;
            for (int i = cnt; i > 0; i--) begin
                m_tag[cfg][s][i] = m_tag[cfg][s][i-1];
                m_data[cfg][s][i] = m_data[cfg][s][i-1];
                m_dirty[cfg][s][i] = m_dirty[cfg][s][i-1];
            end
            cnt++;
        end
        m_tag[cfg][s][0] = t;
        m_data[cfg][s][0] = nd;
        m_dirty[cfg][s][0] = ndirty;
        m_cnt[cfg][s] = cnt;
        d = nd;
    endfunction

    // Backing memories: ack each request after a random 0..3 cycle delay.
    initial begin
        a_mem_ack = 0; b_mem_ack = 0; a_mem_rdata = '0; b_mem_rdata = '0;
        dly[0] = 0; dly[1] = 0;
        forever begin
            @(negedge clock);
            a_mem_ack = 0;
            b_mem_ack = 0;
            if (reset_n && a_mem_req && ack_en[0]) begin
                if (dly[0] > 0) dly[0]--;
                else begin
                    a_mem_ack = 1;
                    if (a_mem_we) begin
                        env_mem[0][a_mem_addr] = int'(a_mem_wdata);
                        wb_cnt[0]++; wb_addr[0] = int'(a_mem_addr); wb_data[0] = int'(a_mem_wdata);
                    end else begin
                        a_mem_rdata = 3'(env_mem[0][a_mem_addr]);
                        rf_cnt[0]++; rf_addr[0] = int'(a_mem_addr);
                    end
                    dly[0] = int'($urandom_range(0, 3));
                end
            end
            if (reset_n && b_mem_req && ack_en[1]) begin
                if (dly[1] > 0) dly[1]--;
                else begin
                    b_mem_ack = 1;
                    if (b_mem_we) begin
                        env_mem[1][b_mem_addr] = int'(b_mem_wdata);
                        wb_cnt[1]++; wb_addr[1] = int'(b_mem_addr); wb_data[1] = int'(b_mem_wdata);
                    end else begin
                        b_mem_rdata = 8'(env_mem[1][b_mem_addr]);
                        rf_cnt[1]++; rf_addr[1] = int'(b_mem_addr);
                    end
                    dly[1] = int'($urandom_range(0, 3));
                end
            end
        end
    end

    function automatic bit rdy(input int cfg);
        return (cfg == 1) ? b_req_ready : a_req_ready;
    endfunction

    function automatic bit rvld(input int cfg);
        return (cfg == 1) ? b_resp_valid : a_resp_valid;
    endfunction

    task automatic do_reset();
        a_req_valid = 0; a_req_wren = 0; a_req_addr = '0; a_req_data = '0;
        b_req_valid = 0; b_req_wren = 0; b_req_addr = '0; b_req_data = '0;
        reset_n = 0;
        repeat (3) @(negedge clock);
        reset_n = 1;
        @(negedge clock);
        for (int c = 0; c < 2; c++) begin
            wb_cnt[c] = 0; rf_cnt[c] = 0; ack_en[c] = 1;
        end
        init_mem();
        model_reset();
    endtask

    // One request/response transaction; lat counts negedges from acceptance to resp_valid (-1 on timeout).
    task automatic acc(input int cfg, input bit wr, input int addr, input int data,
                       output bit hit, output int rd, output int lat, output bit one_pulse);
        int n;
        @(negedge clock);
        if (cfg == 1) begin
            b_req_valid = 1; b_req_wren = wr; b_req_addr = 7'(addr); b_req_data = 8'(data);
        end else begin
            a_req_valid = 1; a_req_wren = wr; a_req_addr = 5'(addr); a_req_data = 3'(data);
        end
        n = 0;
        while (!rdy(cfg) && n < 100) begin @(negedge clock); n++; end
        @(posedge clock);
        @(negedge clock);
        a_req_valid = 0; b_req_valid = 0;
        lat = 1;
        while (!rvld(cfg) && lat < 200) begin @(negedge clock); lat++; end
        if (rvld(cfg)) begin
            hit = (cfg == 1) ? b_resp_hit : a_resp_hit;
            rd = (cfg == 1) ? int'(b_resp_data) : int'(a_resp_data);
        end else begin
            hit = 0; rd = -1; lat = -1;
        end
        @(negedge clock);
        one_pulse = !rvld(cfg);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (a_req_ready !== 1'b1) $display("FAIL reset_ready_a: got %b want 1", a_req_ready); else n_pass++;
        n_checks++;
        if ({a_resp_valid, a_resp_hit, a_resp_data, a_mem_req, a_mem_we, a_mem_addr, a_mem_wdata} !== '0)
            $display("FAIL reset_outputs_a: got %b want 0",
                     {a_resp_valid, a_resp_hit, a_resp_data, a_mem_req, a_mem_we, a_mem_addr, a_mem_wdata});
        else n_pass++;
        n_checks++;
        if ({b_req_ready, b_resp_valid, b_mem_req, b_mem_addr} !== {1'b1, 9'd0})
            $display("FAIL reset_outputs_b: got %b want 1000000000", {b_req_ready, b_resp_valid, b_mem_req, b_mem_addr});
        else n_pass++;
    endtask

    task automatic test_directed_a();
        bit hit, p; int rd, lat, rf0, wb0;
        do_reset();
        env_mem[0][16] = 4;
        env_mem[0][5] = 3;
        rf0 = rf_cnt[0];
        acc(0, 0, 16, 0, hit, rd, lat, p);
        n_checks++; if (hit !== 1'b0 || rd != 4) $display("FAIL first_read: hit %b data %0d want 0/4", hit, rd); else n_pass++;
        n_checks++; if (rf_cnt[0] != rf0 + 1 || rf_addr[0] != 16) $display("FAIL first_refill: cnt %0d addr %0d want %0d/16", rf_cnt[0], rf_addr[0], rf0 + 1); else n_pass++;
        n_checks++; if (p !== 1'b1) $display("FAIL resp_pulse_width: got %b want 1", p); else n_pass++;
        rf0 = rf_cnt[0]; wb0 = wb_cnt[0];
        acc(0, 0, 16, 0, hit, rd, lat, p);
        n_checks++; if (hit !== 1'b1 || rd != 4) $display("FAIL repeat_read: hit %b data %0d want 1/4", hit, rd); else n_pass++;
        n_checks++; if (rf_cnt[0] != rf0 || wb_cnt[0] != wb0) $display("FAIL hit_no_mem: rf %0d wb %0d want %0d/%0d", rf_cnt[0], wb_cnt[0], rf0, wb0); else n_pass++;
        n_checks++; if (lat != 2) $display("FAIL hit_latency: got %0d want 2", lat); else n_pass++;
        wb0 = wb_cnt[0];
        acc(0, 1, 1, 5, hit, rd, lat, p);
        n_checks++; if (hit !== 1'b0 || rd != 5) $display("FAIL write_miss_1: hit %b data %0d want 0/5", hit, rd); else n_pass++;
        acc(0, 1, 9, 4, hit, rd, lat, p);
        n_checks++; if (hit !== 1'b0 || rd != 4) $display("FAIL write_miss_9: hit %b data %0d want 0/4", hit, rd); else n_pass++;
        n_checks++; if (wb_cnt[0] != wb0) $display("FAIL fill_no_writeback: got %0d want %0d", wb_cnt[0], wb0); else n_pass++;
        acc(0, 0, 5, 0, hit, rd, lat, p);
        n_checks++; if (wb_cnt[0] != wb0 + 1 || wb_addr[0] != 1 || wb_data[0] != 5)
            $display("FAIL evict_writeback: cnt %0d addr %0d data %0d want %0d/1/5", wb_cnt[0], wb_addr[0], wb_data[0], wb0 + 1);
        else n_pass++;
        n_checks++; if (rf_addr[0] != 5 || hit !== 1'b0 || rd != 3) $display("FAIL evict_refill: addr %0d hit %b data %0d want 5/0/3", rf_addr[0], hit, rd); else n_pass++;
        acc(0, 0, 9, 0, hit, rd, lat, p);
        n_checks++; if (hit !== 1'b1 || rd != 4) $display("FAIL read_9_hit: hit %b data %0d want 1/4", hit, rd); else n_pass++;
        wb0 = wb_cnt[0];
        acc(0, 0, 13, 0, hit, rd, lat, p);
        n_checks++; if (hit !== 1'b0 || wb_cnt[0] != wb0) $display("FAIL lru_victim_clean: hit %b wb %0d want 0/%0d", hit, wb_cnt[0], wb0); else n_pass++;
        acc(0, 0, 9, 0, hit, rd, lat, p);
        n_checks++; if (hit !== 1'b1 || rd != 4) $display("FAIL mru_kept: hit %b data %0d want 1/4", hit, rd); else n_pass++;
    endtask

    task automatic test_stall_reset();
        bit hit, p, stayed; int rd, lat, n, wb0;
        ack_en[0] = 0;
        @(negedge clock);
        a_req_valid = 1; a_req_wren = 0; a_req_addr = 5'd2;
        @(posedge clock);
        @(negedge clock);
        a_req_valid = 0;
        n = 0;
        while (!a_mem_req && n < 5) begin @(negedge clock); n++; end
        n_checks++; if (a_mem_req !== 1'b1) $display("FAIL stall_refill_start: mem_req %b want 1", a_mem_req); else n_pass++;
        stayed = 1;
        a_req_valid = 1; a_req_wren = 1; a_req_addr = 5'd16; a_req_data = 3'd7;
        repeat (10) begin
            @(negedge clock);
            if (a_mem_req !== 1'b1 || a_req_ready !== 1'b0 || a_mem_we !== 1'b0 || a_mem_addr !== 5'd2) stayed = 0;
        end
        a_req_valid = 0;
        n_checks++; if (stayed !== 1'b1) $display("FAIL stall_hold: got %b want 1", stayed); else n_pass++;
        #2 reset_n = 0;
        #1;
        n_checks++; if (a_mem_req !== 1'b0) $display("FAIL reset_drops_mem_req: got %b want 0", a_mem_req); else n_pass++;
        n_checks++; if (a_req_ready !== 1'b1) $display("FAIL reset_forces_idle: ready %b want 1", a_req_ready); else n_pass++;
        @(negedge clock);
        reset_n = 1;
        ack_en[0] = 1;
        @(negedge clock);
        wb0 = wb_cnt[0];
        acc(0, 0, 16, 0, hit, rd, lat, p);
        n_checks++; if (hit !== 1'b0) $display("FAIL invalid_after_reset_16: hit %b want 0", hit); else n_pass++;
        acc(0, 0, 9, 0, hit, rd, lat, p);
        n_checks++; if (hit !== 1'b0 || wb_cnt[0] != wb0) $display("FAIL dirty_dropped_9: hit %b wb %0d want 0/%0d", hit, wb_cnt[0], wb0); else n_pass++;
        acc(0, 0, 2, 0, hit, rd, lat, p);
        n_checks++; if (hit !== 1'b0) $display("FAIL abandoned_refill_2: hit %b want 0", hit); else n_pass++;
    endtask

    task automatic test_lru_4way();
        bit hit, p; int rd, lat;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            acc(1, 1, t * 8 + 3, 16 + t, hit, rd, lat, p);
            n_checks++; if (hit !== 1'b0 || rd != 16 + t) $display("FAIL fill4_tag%0d: hit %b data %0d want 0/%0d", t, hit, rd, 16 + t); else n_pass++;
        end
        n_checks++; if (wb_cnt[1] != 0) $display("FAIL fill4_no_evict: wb %0d want 0", wb_cnt[1]); else n_pass++;
        for (int t = 0; t < 4; t++) begin
            acc(1, 0, t * 8 + 3, 0, hit, rd, lat, p);
            n_checks++; if (hit !== 1'b1 || rd != 16 + t) $display("FAIL reread4_tag%0d: hit %b data %0d want 1/%0d", t, hit, rd, 16 + t); else n_pass++;
        end
        acc(1, 0, 4 * 8 + 3, 0, hit, rd, lat, p);
        n_checks++; if (hit !== 1'b0 || wb_cnt[1] != 1 || wb_addr[1] != 3 || wb_data[1] != 16)
            $display("FAIL fifth_evicts_lru: hit %b wb %0d addr %0d data %0d want 0/1/3/16", hit, wb_cnt[1], wb_addr[1], wb_data[1]);
        else n_pass++;
        acc(1, 0, 1 * 8 + 3, 0, hit, rd, lat, p);
        n_checks++; if (hit !== 1'b1 || rd != 17) $display("FAIL survivor_tag1: hit %b data %0d want 1/17", hit, rd); else n_pass++;
        acc(1, 0, 3, 0, hit, rd, lat, p);
        n_checks++; if (hit !== 1'b0 || rd != 16) $display("FAIL evicted_tag0: hit %b data %0d want 0/16", hit, rd); else n_pass++;
    endtask

    task automatic test_random(input int cfg, input int n);
        bit wr, hit, p, eh, ewb; int addr, data, rd, lat, ed, ewba, ewbd, wb0, rf0;
        do_reset();
        for (int i = 0; i < n; i++) begin
            wr = 1'($urandom_range(0, 1));
            addr = (cfg == 1) ? int'($urandom_range(0, 7)) * 8 + int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            data = int'($urandom_range(0, (cfg == 1) ? 255 : 7));
            model_access(cfg, wr, addr, data, eh, ed, ewb, ewba, ewbd);
            wb0 = wb_cnt[cfg]; rf0 = rf_cnt[cfg];
            acc(cfg, wr, addr, data, hit, rd, lat, p);
            n_checks++;
            if (lat < 0 || hit !== eh || rd != ed || p !== 1'b1)
                $display("FAIL rand%0d_%0d resp: addr %0d wr %b hit %b data %0d lat %0d pulse %b want hit %b data %0d",
                         cfg, i, addr, wr, hit, rd, lat, p, eh, ed);
            else n_pass++;
            n_checks++;
            if ((wb_cnt[cfg] - wb0) != int'(ewb) || (rf_cnt[cfg] - rf0) != int'(!eh))
                $display("FAIL rand%0d_%0d memops: wb %0d rf %0d want %0d/%0d", cfg, i, wb_cnt[cfg] - wb0, rf_cnt[cfg] - rf0, ewb, !eh);
            else n_pass++;
            if (ewb) begin
                n_checks++;
                if (wb_addr[cfg] != ewba || wb_data[cfg] != ewbd)
                    $display("FAIL rand%0d_%0d wbline: addr %0d data %0d want %0d/%0d", cfg, i, wb_addr[cfg], wb_data[cfg], ewba, ewbd);
                else n_pass++;
            end
            if (!eh) begin
                n_checks++;
                if (rf_addr[cfg] != addr) $display("FAIL rand%0d_%0d refill_addr: got %0d want %0d", cfg, i, rf_addr[cfg], addr); else n_pass++;
            end else begin
                n_checks++;
                if (lat != 2) $display("FAIL rand%0d_%0d hit_latency: got %0d want 2", cfg, i, lat); else n_pass++;
            end
        end
    endtask

    initial begin
        reset_n = 0;
        ack_en[0] = 1; ack_en[1] = 1;
        test_reset();
        test_directed_a();
        test_stall_reset();
        test_lru_4way();
        test_random(0, 150);
        test_random(1, 150);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
